// File: rtl/fb_pkg.sv
// Shared types and defaults for the single-frame pixel buffer.
package fb_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} fb_rd_state_t;

  localparam int FB_DATA_W = 8;
  localparam int FB_IMG_W  = 160;
  localparam int FB_IMG_H  = 240;

  function automatic int fb_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fb_if.sv
// Write-stream, control and read-stream signals of the frame buffer.
interface fb_if import fb_pkg::*; #(
  parameter int DATA_W = FB_DATA_W
) ();

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sof;
  logic              wr_ready;
  logic              wr_frame_done;
  logic              frame_valid;
  logic              rd_start;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;

  modport master (
    output wr_valid, wr_data, wr_sof, rd_start, rd_ready,
    input  wr_ready, wr_frame_done, frame_valid, rd_busy, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, wr_sof, rd_start, rd_ready,
    output wr_ready, wr_frame_done, frame_valid, rd_busy, rd_valid, rd_data, rd_last
  );

endinterface

// File: rtl/fb_skid_fifo.sv
// Small fall-through FIFO absorbing in-flight BRAM reads under backpressure.
module fb_skid_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     slot [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CNT_W-1:0] cnt;
  logic             empty, bypass, push, pop_slot;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An arriving beat goes straight to the output when nothing is queued ahead of it.
  assign empty     = (cnt == '0);
  assign bypass    = empty & in_valid;
  assign out_valid = ~empty | in_valid;
  assign out_data  = bypass ? in_data : slot[head];
  assign push      = in_valid & ~(bypass & out_ready);
  assign pop_slot  = ~empty & out_ready;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      if (push) begin
        slot[tail] <= in_data;
        tail       <= nxt(tail);
      end
      if (pop_slot) head <= nxt(head);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop_slot);
    end
  end

endmodule

// File: rtl/frame_buffer_stream.sv
// Single-frame raster buffer: stream in, stream the stored frame out with backpressure.
// FB_OUTREG_EN adds a BRAM output register (read latency 2, three-entry skid FIFO).
//
//   state | meaning
//   IDLE  | accepting writes, waiting for rd_start with a stored frame
//   READ  | issuing BRAM reads 0..DEPTH-1 as FIFO space allows
//   DRAIN | all reads issued, waiting for the rd_last beat to be taken
module frame_buffer_stream import fb_pkg::*; #(
  parameter int DATA_W = FB_DATA_W,
  parameter int IMG_W  = FB_IMG_W,
  parameter int IMG_H  = FB_IMG_H
) (
  input  logic clk,
  input  logic rst_n,
  fb_if.slave  bus
);

  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = fb_addr_w(DEPTH);
`ifdef FB_OUTREG_EN
  localparam int FIFO_DEPTH = 3;
`else
  localparam int FIFO_DEPTH = 2;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  fb_rd_state_t      state;
  logic [ADDR_W-1:0] wr_ptr, wr_addr, rd_ptr;
  logic              wr_fire, wr_ready_q, wr_done_q, frame_valid_q, rd_busy_q;
  logic              issue, issue_last, rd_fire, rd_done;
  logic [DATA_W-1:0] mem_q;
  logic              v1, last1;
  logic              fifo_in_valid, fifo_out_valid;
  logic [DATA_W:0]   fifo_in_data, fifo_out_data;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;

  assign wr_fire = bus.wr_valid & wr_ready_q;
  assign wr_addr = bus.wr_sof ? '0 : wr_ptr;

  // Writes and reads never overlap: writes only in IDLE, reads only in READ.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= bus.wr_data;
    if (issue)   mem_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      wr_done_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      wr_done_q <= wr_fire && (wr_addr == LAST_ADDR);
      if (wr_fire)
        wr_ptr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
      else if (bus.wr_sof)
        wr_ptr <= '0;
      if (wr_done_q)
        frame_valid_q <= 1'b1;
      else if (wr_fire || rd_done)
        frame_valid_q <= 1'b0;
    end
  end

  // Only issue a read when every beat already in flight is guaranteed a FIFO slot.
  assign issue      = (state == READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last = (rd_ptr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v1    <= issue;
      last1 <= issue && issue_last;
    end
  end

`ifdef FB_OUTREG_EN
  logic [DATA_W-1:0] mem_q2;
  logic              v2, last2;

  always_ff @(posedge clk) mem_q2 <= mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
    end else begin
      v2    <= v1;
      last2 <= last1;
    end
  end

  assign occupancy     = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(v1) + (CNT_W+1)'(v2);
  assign fifo_in_valid = v2;
  assign fifo_in_data  = {last2, mem_q2};
`else
  assign occupancy     = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(v1);
  assign fifo_in_valid = v1;
  assign fifo_in_data  = {last1, mem_q};
`endif

  fb_skid_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fifo_in_valid),
    .in_data   (fifo_in_data),
    .out_valid (fifo_out_valid),
    .out_data  (fifo_out_data),
    .out_ready (bus.rd_ready),
    .count     (fifo_count)
  );

  assign rd_fire = fifo_out_valid & bus.rd_ready;
  assign rd_done = rd_fire & fifo_out_data[DATA_W] & (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      rd_busy_q  <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_start && frame_valid_q) begin
            state      <= READ;
            rd_ptr     <= '0;
            rd_busy_q  <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        READ: begin
          if (issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_done) begin
            state      <= IDLE;
            rd_busy_q  <= 1'b0;
            wr_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          rd_busy_q  <= 1'b0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready      = wr_ready_q;
  assign bus.wr_frame_done = wr_done_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.rd_busy       = rd_busy_q;
  assign bus.rd_valid      = fifo_out_valid;
  assign bus.rd_data       = fifo_out_data[DATA_W-1:0];
  assign bus.rd_last       = fifo_out_data[DATA_W];

endmodule

// File: tb/tb_frame_buffer_stream.sv
// Scoreboard bench for frame_buffer_stream on a reduced 32x24 frame.
module tb_frame_buffer_stream;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 24;
  localparam int DEPTH     = IMG_W * IMG_H;
  localparam int RST_BEAT  = 100;
`ifdef FB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  fb_if #(.DATA_W(8)) bus ();

  frame_buffer_stream #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         vectors = 0, miscompares = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [8:0] exp_q [$];
  int         m_ptr = 0, last_wr_cyc = 0, done_cnt = 0, done_cyc = 0;
  int         start_cyc = 0, first_cyc = -1, last_acc_cyc = 0, acc_cnt = 0;
  bit         armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference write model: sof redirects the beat to address 0, a beat at DEPTH-1 wraps.
  task automatic wr_beat(input logic [7:0] d, input logic sof);
    int addr;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_sof   = sof;
    addr = sof ? 0 : m_ptr;
    ref_mem[addr] = d;
    if (addr == DEPTH - 1) begin
      m_ptr = 0;
      last_wr_cyc = cyc;
    end else begin
      m_ptr = addr + 1;
    end
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
  endtask

  task automatic write_frame(input bit pattern);
    for (int i = 0; i < DEPTH; i++) wr_beat(pattern ? 8'(i) : 8'($urandom), 1'b0);
  endtask

  task automatic check_done();
    repeat (3) tick();
    check("frame_done_count", done_cnt, 1);
    check("frame_done_cycle", done_cyc - last_wr_cyc, 1);
    check("frame_valid_set", bus.frame_valid, 1);
    check("idle_not_busy", bus.rd_busy, 0);
    done_cnt = 0;
  endtask

  task automatic start_read();
    acc_cnt = 0;
    first_cyc = -1;
    bus.rd_ready = 1'b1;
    bus.rd_start = 1'b1;
    start_cyc = cyc;
    armed = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), ref_mem[i]});
    tick();
    bus.rd_start = 1'b0;
  endtask

  task automatic finish_read(input bit rand_ready, input bit junk_writes);
    for (int n = 0; n < 8 * DEPTH; n++) begin
      if (exp_q.size() == 0) break;
      if (junk_writes) begin
        check("wr_ready_during_read", bus.wr_ready, 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'($urandom);
      end
      bus.rd_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    check("read_complete", exp_q.size(), 0);
    repeat (2) tick();
    check("rd_busy_cleared", bus.rd_busy, 0);
    check("frame_valid_cleared", bus.frame_valid, 0);
    check("rd_latency", first_cyc - start_cyc, LAT);
    if (!rand_ready) check("rd_no_bubbles", last_acc_cyc - first_cyc, DEPTH - 1);
  endtask

  task automatic probe_ignored();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    repeat (6) begin
      check("rd_start_ignored_busy", bus.rd_busy, 0);
      check("rd_start_ignored_valid", bus.rd_valid, 0);
      tick();
    end
  endtask

  initial begin
    logic [8:0] exp_beat, prev_beat;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("rd_hold_valid", bus.rd_valid, 1);
          check("rd_hold_beat", {bus.rd_last, bus.rd_data}, prev_beat);
        end
        if (armed && bus.rd_valid) begin
          first_cyc = cyc;
          armed = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("rd_valid_unexpected", bus.rd_valid, 0);
        end else if (bus.rd_valid && bus.rd_ready) begin
          exp_beat = exp_q.pop_front();
          check("rd_beat", {bus.rd_last, bus.rd_data}, exp_beat);
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        prev_stall = bus.rd_valid && !bus.rd_ready;
        prev_beat  = {bus.rd_last, bus.rd_data};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.wr_frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_sof   = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_wr_ready", bus.wr_ready, 1);
    check("reset_wr_frame_done", bus.wr_frame_done, 0);
    check("reset_frame_valid", bus.frame_valid, 0);
    check("reset_rd_busy", bus.rd_busy, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_rd_data", bus.rd_data, 0);
    check("reset_rd_last", bus.rd_last, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    write_frame(1'b1);
    check_done();
    start_read();
    finish_read(1'b0, 1'b0);

    probe_ignored();

    write_frame(1'b0);
    check_done();
    start_read();
    finish_read(1'b1, 1'b1);

    write_frame(1'b0);
    check_done();
    start_read();
    finish_read(1'b0, 1'b0);

    for (int i = 0; i < 100; i++) wr_beat(8'($urandom), 1'b0);
    wr_beat(8'hAA, 1'b1);
    tick();
    check("sof_no_early_done", done_cnt, 0);
    check("sof_no_early_valid", bus.frame_valid, 0);
    for (int i = 0; i < DEPTH - 1; i++) wr_beat(8'($urandom), 1'b0);
    check_done();
    start_read();
    finish_read(1'b1, 1'b0);

    write_frame(1'b0);
    check_done();
    start_read();
    for (int n = 0; n < 4 * DEPTH; n++) begin
      if (acc_cnt >= RST_BEAT) break;
      tick();
    end
    check("rst_at_beat", acc_cnt, RST_BEAT);
    rst_n = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    #1;
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_frame_valid", bus.frame_valid, 0);
    check("midrst_rd_busy", bus.rd_busy, 0);
    check("midrst_wr_ready", bus.wr_ready, 1);
    check("midrst_rd_last", bus.rd_last, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    probe_ignored();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
